// File: rtl/dii_packet_arbiter_pkg.sv
// Shared DII flit type used by every port of the packet arbiter.
package dii_package;

  localparam int DII_DATA_W = 16;

  typedef struct packed {
    logic [DII_DATA_W-1:0] data;
    logic                  last;
    logic                  valid;
  } dii_flit;

endpackage

// File: rtl/dii_packet_arbiter_rr.sv
// Round-robin winner search: lowest requester strictly above last_grant,
// otherwise the lowest requester overall (wrap N-1 -> 0).
module dii_rr_select #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last_grant,
  output logic [$clog2(N)-1:0] winner,
  output logic                 any
);

  localparam int W = $clog2(N);

  logic [N-1:0] upper_mask;
  logic [N-1:0] upper_req;

  // Ports with a higher index than the previous owner get first claim.
  always_comb begin
    upper_mask = '0;
    for (int i = 0; i < N; i++) begin
      if (i > int'(last_grant)) upper_mask[i] = 1'b1;
    end
  end

  assign upper_req = req & upper_mask;

  // Lowest set bit of the upper half wins; fall back to lowest set bit overall.
  always_comb begin
    winner = '0;
    any    = |req;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) winner = W'(i);
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (upper_req[i]) winner = W'(i);
    end
  end

endmodule

// File: rtl/dii_packet_arbiter.sv
// Packet-granular round-robin arbiter for N DII ports with one registered
// output stage. A granted port owns the output until its last flit is taken.
module dii_packet_arbiter
  import dii_package::*;
#(
  parameter int N = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  dii_flit              in_flit [N],
  output logic [N-1:0]         in_ready,
  output dii_flit              out_flit,
  input  logic                 out_ready,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 grant_active
);

  localparam int W = $clog2(N);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t         state, state_nxt;
  logic [W-1:0]   last_grant;
  logic [W-1:0]   rr_winner;
  logic           rr_any;
  logic [N-1:0]   req;
  dii_flit        sel_flit;
  logic           slot_free;
  logic           accept;

  // Request vector is just the per-port valid bits.
  always_comb begin
    req = '0;
    for (int i = 0; i < N; i++) req[i] = in_flit[i].valid;
  end

  dii_rr_select #(.N(N)) u_rr (
    .req        (req),
    .last_grant (last_grant),
    .winner     (rr_winner),
    .any        (rr_any)
  );

  assign sel_flit     = in_flit[grant_id];
  assign slot_free    = ~out_flit.valid | out_ready;
  assign grant_active = (state == LOCKED);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state, per-port ready and input acceptance.
  always_comb begin
    state_nxt = state;
    in_ready  = '0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (rr_any) state_nxt = LOCKED;
      end
      LOCKED: begin
        in_ready[grant_id] = slot_free;
        accept             = slot_free & sel_flit.valid;
        if (accept && sel_flit.last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Grant bookkeeping: latch the winner in IDLE, remember owner at packet end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_id   <= '0;
      last_grant <= W'(N - 1);
    end else begin
      if (state == IDLE && rr_any) grant_id <= rr_winner;
      if (accept && sel_flit.last) last_grant <= grant_id;
    end
  end

  // Output register: load on accept, drain when downstream takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_flit <= '0;
    end else if (accept) begin
      out_flit.data  <= sel_flit.data;
      out_flit.last  <= sel_flit.last;
      out_flit.valid <= 1'b1;
    end else if (out_ready) begin
      out_flit.valid <= 1'b0;
    end
  end

endmodule
